mux_n_pipe: RTL and testbench

Parametrised N-input selector with a registered, valid/ready-handshaked output stage and a one-entry skid buffer. It is the next-generation replacement for the fixed 3:1 combinational data muxes in the datapath, for use wherever a selected operand crosses a pipeline boundary that can stall. It also flags out-of-range selects per beat and keeps a saturating count of them for debug.

---
 rtl/mux_n_pipe_pkg.sv | 16 +
 rtl/mux_n_pipe_skid_reg.sv | 66 ++++++
 rtl/mux_n_pipe.sv | 65 ++++++
 tb/tb_mux_n_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pipe_pkg.sv
// Shared datapath definitions for the N-input selector pipeline.
package mux_n_pipe_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Beat layout at the default width; other widths carry the same {data, err} as a packed vector.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          err;
  } beat_t;

  function automatic logic sel_oob(input int unsigned sel, input int unsigned n);
    return sel >= n;
  endfunction

endpackage

// File: rtl/mux_n_pipe_skid_reg.sv
// Generic 1-deep skid/pipeline register with valid/ready; in_ready is registered.
module skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: begin
          if (accept && !drain) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= TWO;
          end else if (accept && drain) begin
            // new beat bypasses the skid so streaming keeps 1 beat/cycle
            out_data <= in_data;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: if (drain) begin
          out_data <= skid_data;
          in_ready <= 1'b1;
          state    <= ONE;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input selector with registered valid/ready output, skid buffer and saturating error count.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned  NUM_INPUTS    = 3,
  parameter int unsigned  ERR_CNT_WIDTH = 8,
  localparam int unsigned SEL_WIDTH     = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SEL_WIDTH-1:0]             mux_sel,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            d_out,
  output logic                             out_err,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt,
  input  logic                             err_clr
);

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_err;
  logic [DATA_WIDTH:0]   pipe_out;
  logic                  accept;

  // out-of-range selects fall back to input 0, matching the legacy muxes
  always_comb begin
    sel_err  = sel_oob(32'(mux_sel), NUM_INPUTS);
    sel_data = in_data[0 +: DATA_WIDTH];
    for (int unsigned k = 1; k < NUM_INPUTS; k++) begin
      if (32'(mux_sel) == k) sel_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  skid_reg #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({sel_data, sel_err}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pipe_out)
  );

  assign d_out   = pipe_out[DATA_WIDTH:1];
  assign out_err = pipe_out[0];
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && sel_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: select, errors, backpressure, streaming, saturation, reset.
module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mux_sel;
  logic [95:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_out;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic        err_clr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mux_n_pipe #(
    .DATA_WIDTH   (32),
    .NUM_INPUTS   (3),
    .ERR_CNT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mux_sel  (mux_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d_out    (d_out),
    .out_err  (out_err),
    .err_cnt  (err_cnt),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] prev_exp;
    logic [32:0] got_beat;
    logic        prev_acc;
    logic [95:0] din;
    int unsigned sent;
    int unsigned got;
    int unsigned s;

    rst = 1'b1; in_valid = 1'b0; mux_sel = '0; in_data = '0; out_ready = 1'b1; err_clr = 1'b0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    // 1: legal selects, 1-cycle latency, full throughput
    in_data = {32'hC, 32'hB, 32'hA};
    in_valid = 1'b1; mux_sel = 2'd0;
    step();
    chk("t1_valid0", out_valid, 1); chk("t1_d0", d_out, 32'hA); chk("t1_err0", out_err, 0);
    mux_sel = 2'd1;
    step();
    chk("t1_d1", d_out, 32'hB); chk("t1_err1", out_err, 0);
    mux_sel = 2'd2;
    step();
    chk("t1_d2", d_out, 32'hC); chk("t1_err2", out_err, 0);
    in_valid = 1'b0;
    step();
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_hold", d_out, 32'hC);

    // 2: out-of-range select falls back to input 0
    in_data = {32'h3333, 32'h55, 32'h1234};
    in_valid = 1'b1; mux_sel = 2'd3;
    step();
    chk("t2_d", d_out, 32'h1234); chk("t2_err", out_err, 1); chk("t2_cnt", err_cnt, 1);
    mux_sel = 2'd1;
    step();
    chk("t2_legal_d", d_out, 32'h55); chk("t2_legal_err", out_err, 0); chk("t2_legal_cnt", err_cnt, 1);
    in_valid = 1'b0;
    step();
    chk("t2_drained", out_valid, 0);

    // 3: backpressure fills output and skid, third beat refused
    out_ready = 1'b0; in_valid = 1'b1; mux_sel = 2'd0;
    in_data = {64'h0, 32'h111};
    step();
    chk("t3_b1_d", d_out, 32'h111); chk("t3_b1_ready", in_ready, 1);
    in_data = {64'h0, 32'h222};
    step();
    chk("t3_b2_hold", d_out, 32'h111); chk("t3_b2_ready", in_ready, 0);
    in_data = {64'h0, 32'h333};
    step();
    chk("t3_b3_hold", d_out, 32'h111); chk("t3_b3_ready", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("t3_out2_valid", out_valid, 1); chk("t3_out2_d", d_out, 32'h222); chk("t3_out2_ready", in_ready, 1);
    step();
    chk("t3_empty", out_valid, 0); chk("t3_empty_hold", d_out, 32'h222);

    // 4: random stream with out_ready toggling, scoreboard in order
    prev_acc = 1'b0; prev_exp = '0; sent = 0; got = 0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 8000 && (sent < 1000 || q.size() != 0 || prev_acc); cyc++) begin
      step();
      if (prev_acc) q.push_back(prev_exp);
      out_ready = ~out_ready;
      if (out_valid && out_ready) begin
        chk("t4_q_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) begin
          got_beat = q.pop_front();
          got++;
          chk("t4_beat", {d_out, out_err}, got_beat);
        end
      end
      if (sent < 1000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        s = $urandom_range(0, 3);
        mux_sel = 2'(s);
        din = {$urandom, $urandom, $urandom};
        in_data = din;
        prev_exp = (s < 3) ? {din[s*32 +: 32], 1'b0} : {din[31:0], 1'b1};
      end else begin
        in_valid = 1'b0;
      end
      prev_acc = in_valid && in_ready;
      if (prev_acc) sent++;
    end
    in_valid = 1'b0;
    chk("t4_sent", sent, 1000);
    chk("t4_got", got, 1000);
    chk("t4_q_empty", q.size(), 0);

    // 5: saturation and clear priority
    out_ready = 1'b1; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_cleared", err_cnt, 0);
    for (int i = 1; i <= 300; i++) begin
      in_valid = 1'b1; mux_sel = 2'd3; in_data = {$urandom, $urandom, $urandom};
      step();
      if (i == 100) chk("t5_cnt100", err_cnt, 100);
      if (i == 255) chk("t5_cnt255", err_cnt, 255);
    end
    in_valid = 1'b0;
    chk("t5_sat", err_cnt, 255);
    in_valid = 1'b1; mux_sel = 2'd3; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_clr_prio", err_cnt, 0);
    step();
    in_valid = 1'b0;
    chk("t5_inc_after_clr", err_cnt, 1);
    step();

    // 6: reset while full (TWO)
    out_ready = 1'b0; in_valid = 1'b1; mux_sel = 2'd1;
    in_data = {32'h0, 32'hAAA, 32'h0};
    step();
    in_data = {32'h0, 32'hBBB, 32'h0};
    step();
    in_valid = 1'b0;
    chk("t6_full_ready", in_ready, 0);
    chk("t6_full_d", d_out, 32'hAAA);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_d", d_out, 0);
    chk("t6_async_cnt", err_cnt, 0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    chk("t6_ready_after", in_ready, 1);
    step();
    chk("t6_no_stale1", out_valid, 0);
    step();
    chk("t6_no_stale2", out_valid, 0);
    chk("t6_d_zero", d_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
